// File: rtl/threshold_press_pkg.sv
// threshold_press_pkg: shared types and widths for the threshold press generator.
package threshold_press_pkg;
    typedef enum logic [1:0] {CMP_LT, CMP_LE, CMP_GT, CMP_GE} cmp_mode_t;
    typedef enum logic [1:0] {IDLE, FIRE, COOL, WAIT_REL} press_state_t;
    // Cooldown counter is sized for the largest legal COOLDOWN (255)
    localparam int COOLDOWN_MAX = 255;
    localparam int CNT_W = $clog2(COOLDOWN_MAX + 1);
endpackage

// File: rtl/threshold_press_gen_if.sv
// threshold_press_gen_if: operand/mode inputs and press outputs of the press generator.
interface threshold_press_gen_if
    import threshold_press_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2
);
    logic                             enable;
    cmp_mode_t                        mode;
    logic [CHANNELS-1:0][WIDTH-1:0]   a;
    logic [CHANNELS-1:0][WIDTH-1:0]   b;
    logic [CHANNELS-1:0]              pressed;
    logic [CHANNELS-1:0]              press_pulse;
    logic [CHANNELS-1:0]              busy;
    logic [CHANNELS-1:0][7:0]         press_count;

    modport master (
        output enable, mode, a, b,
        input  pressed, press_pulse, busy, press_count
    );
    modport slave (
        input  enable, mode, a, b,
        output pressed, press_pulse, busy, press_count
    );
endinterface

// File: rtl/threshold_press_gen_channel.sv
// press_channel: one compare channel with press FSM, cooldown and optional press counter.
// Optional saturating press counter is built when PRESS_COUNT_EN is defined.
module press_channel
    import threshold_press_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int COOLDOWN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  cmp_mode_t        mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             pressed,
    output logic             press_pulse,
    output logic             busy,
    output logic [7:0]       press_count
);
    logic             cmp;
    press_state_t     state;
    logic [CNT_W-1:0] cnt;

    always_comb cmp = mode == CMP_LT ? a < b :
                      mode == CMP_LE ? a <= b :
                      mode == CMP_GT ? a > b : a >= b;

    assign press_pulse = state == FIRE;
    assign busy        = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            pressed <= enable & cmp;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE:     if (cmp) state <= FIRE;
                    FIRE: begin
                        state <= COOL;
                        cnt   <= CNT_W'(COOLDOWN - 1);
                    end
                    // Only the compare value seen at the final cooldown cycle matters
                    COOL:     if (cnt == '0) state <= cmp ? WAIT_REL : IDLE;
                              else cnt <= cnt - 1'b1;
                    WAIT_REL: if (!cmp) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

`ifdef PRESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) press_count <= '0;
        else if (press_pulse && press_count != 8'hff) press_count <= press_count + 8'd1;
    end
`else
    assign press_count = '0;
`endif
endmodule

// File: rtl/threshold_press_gen.sv
// threshold_press_gen: multi-channel compare-and-press generator for the frog input path.
// Define PRESS_COUNT_EN to build the per-channel saturating press counters.
module threshold_press_gen
    import threshold_press_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2,
    parameter int COOLDOWN = 8
) (
    input logic                  clk,
    input logic                  reset,
    threshold_press_gen_if.slave bus
);
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            press_channel #(.WIDTH(WIDTH), .COOLDOWN(COOLDOWN)) u_ch (
                .clk         (clk),
                .reset       (reset),
                .enable      (bus.enable),
                .mode        (bus.mode),
                .a           (bus.a[i]),
                .b           (bus.b[i]),
                .pressed     (bus.pressed[i]),
                .press_pulse (bus.press_pulse[i]),
                .busy        (bus.busy[i]),
                .press_count (bus.press_count[i])
            );
        end
    endgenerate
endmodule
